// File: rtl/sdc_multi_blk_rd_seq.sv
// sdc_multi_blk_rd_seq: sequences the single-block read datapath through an N-block SD read,
// writing each 64-bit word to BRAM and checking every block's CRC16 under start/CRC timeouts.
module sdc_multi_blk_rd_seq #(
    parameter int          AW       = 9,
    parameter int          BCW      = 8,
    parameter logic [15:0] TOUT     = 16'd4096,
    parameter logic [5:0]  CRC_TOUT = 6'd32
) (
    input  logic           sdc_clk,
    input  logic           reset,
    input  logic           rd_start,
    input  logic [BCW-1:0] blk_num,
    input  logic [AW-1:0]  base_addr,
    input  logic           wrd_rdy_strb,
    input  logic [63:0]    dat_wrd,
    input  logic           crc_rdy_strb,
    input  logic [15:0]    crc_16,
    input  logic [15:0]    crc_calc,
    output logic           adma_end,
    output logic           bram_we,
    output logic [AW-1:0]  bram_addr,
    output logic [63:0]    bram_din,
    output logic           busy,
    output logic           done_strb,
    output logic           err_strb,
    output logic [1:0]     err_code,
    output logic [BCW-1:0] blks_done
);
    typedef enum logic [6:0] {
        IDLE     = 7'b0000001,
        ARM      = 7'b0000010,
        RD_WRDS  = 7'b0000100,
        WAIT_CRC = 7'b0001000,
        CHECK    = 7'b0010000,
        DONE     = 7'b0100000,
        ERR      = 7'b1000000
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d, bram_addr_q, bram_addr_d;
    logic [BCW-1:0] rem_q, rem_d, blks_q, blks_d;
    logic [1:0]     code_q, code_d;
    logic [15:0]    timer_q, timer_d;
    logic [6:0]     wcnt_q, wcnt_d;
    logic           crc_ok_q, crc_ok_d, we_q, we_d, done_q, err_q;
    logic [63:0]    din_q, din_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        blks_d      = blks_q;
        code_d      = code_q;
        wcnt_d      = wcnt_q;
        crc_ok_d    = crc_ok_q;
        we_d        = 1'b0;
        din_d       = din_q;
        bram_addr_d = bram_addr_q;
        case (state_q)
            IDLE: if (rd_start) begin
                addr_d  = base_addr;
                rem_d   = blk_num;
                blks_d  = '0;
                code_d  = 2'b00;
                state_d = (blk_num == '0) ? DONE : ARM;
            end
            ARM: if (wrd_rdy_strb) begin
                wcnt_d  = 7'd1;
                state_d = RD_WRDS;
            end else if (timer_q == TOUT - 16'd1) begin
                code_d  = 2'b01;
                state_d = ERR;
            end
            RD_WRDS: if (wrd_rdy_strb) begin
                wcnt_d  = wcnt_q + 7'd1;
                state_d = (wcnt_q == 7'd63) ? WAIT_CRC : RD_WRDS;
            end
            // a CRC strobe arriving on the timeout cycle still counts
            WAIT_CRC: if (crc_rdy_strb) begin
                crc_ok_d = (crc_16 == crc_calc);
                state_d  = CHECK;
            end else if (timer_q == 16'(CRC_TOUT) - 16'd1) begin
                code_d  = 2'b10;
                state_d = ERR;
            end
            CHECK: if (crc_ok_q) begin
                blks_d  = blks_q + BCW'(1);
                rem_d   = rem_q - BCW'(1);
                state_d = (rem_q == BCW'(1)) ? DONE : ARM;
            end else begin
                code_d  = 2'b11;
                state_d = ERR;
            end
            default: state_d = IDLE;
        endcase
        if (wrd_rdy_strb && (state_q == ARM || state_q == RD_WRDS)) begin
            we_d        = 1'b1;
            din_d       = dat_wrd;
            bram_addr_d = addr_q;
            addr_d      = addr_q + AW'(1);
        end
        timer_d = (state_d != state_q || state_q == IDLE) ? 16'd0 : timer_q + 16'd1;
    end

    always_ff @(posedge sdc_clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            bram_addr_q <= '0;
            rem_q       <= '0;
            blks_q      <= '0;
            code_q      <= 2'b00;
            timer_q     <= 16'd0;
            wcnt_q      <= 7'd0;
            crc_ok_q    <= 1'b0;
            we_q        <= 1'b0;
            din_q       <= 64'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            bram_addr_q <= bram_addr_d;
            rem_q       <= rem_d;
            blks_q      <= blks_d;
            code_q      <= code_d;
            timer_q     <= timer_d;
            wcnt_q      <= wcnt_d;
            crc_ok_q    <= crc_ok_d;
            we_q        <= we_d;
            din_q       <= din_d;
            done_q      <= (state_q == DONE);
            err_q       <= (state_q == ERR);
        end
    end

    // datapath only runs while a block is armed or in flight
    assign adma_end  = !(state_q == ARM || state_q == RD_WRDS || state_q == WAIT_CRC);
    assign busy      = (state_q != IDLE);
    assign bram_we   = we_q;
    assign bram_addr = bram_addr_q;
    assign bram_din  = din_q;
    assign done_strb = done_q;
    assign err_strb  = err_q;
    assign err_code  = code_q;
    assign blks_done = blks_q;
endmodule
